// File: rtl/mem_branch_resolve.sv
// EX/MEM branch register and MEM-stage beq/bne resolution. It drives the next-PC select and the
// younger-stage squash. Optional saturating statistics counters are built with ARC_BRANCH_STATS_EN.
module mem_branch_resolve #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_con_stall,
  input  logic             i_con_validE,
  input  logic             i_con_branchE,
  input  logic             i_con_bneE,
  input  logic             i_flag_zeroE,
  input  logic [WIDTH-1:0] i_addr_pcbranchE,
  input  logic             i_con_excack,
  output logic [WIDTH-1:0] o_addr_pcbranchM,
  output logic             o_con_PCSrc,
  output logic             o_con_flushD,
  output logic             o_con_flushE,
  output logic             o_exc_misalign,
  output logic [CNT_W-1:0] o_cnt_branch,
  output logic [CNT_W-1:0] o_cnt_taken
);

  typedef enum logic [1:0] {StIdle, StRedirect, StHold} state_e;

  state_e           state_q;
  logic             valid_q, branch_q, bne_q, zero_q;
  logic [WIDTH-1:0] pcbranch_q;
  logic             exc_q;

  logic taken_e, aligned_e, redirect_e;
  logic taken_m, misalign_m;

  // beq takes priority when both decode bits are set.
  always_comb begin
    taken_e    = i_con_validE & (i_con_branchE ? i_flag_zeroE : (i_con_bneE & ~i_flag_zeroE));
    aligned_e  = (i_addr_pcbranchE[1:0] == 2'b00);
    redirect_e = taken_e & aligned_e;
    taken_m    = valid_q & (branch_q ? zero_q : (bne_q & ~zero_q));
    misalign_m = taken_m & (pcbranch_q[1:0] != 2'b00);
  end

  // The state register carries the redirect decision. It matches takenM & aligned for the
  // loaded MEM contents, so PCSrc comes straight from a flop.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= StIdle;
      valid_q    <= 1'b0;
      branch_q   <= 1'b0;
      bne_q      <= 1'b0;
      zero_q     <= 1'b0;
      pcbranch_q <= '0;
    end else if (!i_con_stall) begin
      if (state_q != StIdle) begin
        // Self-squash: the EX instruction is on the wrong path.
        valid_q <= 1'b0;
        state_q <= StIdle;
      end else begin
        valid_q    <= i_con_validE;
        branch_q   <= i_con_branchE;
        bne_q      <= i_con_bneE;
        zero_q     <= i_flag_zeroE;
        pcbranch_q <= i_addr_pcbranchE;
        state_q    <= redirect_e ? StRedirect : StIdle;
      end
    end else if (state_q == StRedirect) begin
      state_q <= StHold;
    end
  end

  // Sticky misalign flag; a new set wins over a simultaneous ack.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      exc_q <= 1'b0;
    end else begin
      exc_q <= misalign_m | (exc_q & ~i_con_excack);
    end
  end

  always_comb begin
    o_con_PCSrc      = (state_q != StIdle);
    o_con_flushD     = o_con_PCSrc;
    o_con_flushE     = o_con_PCSrc;
    o_addr_pcbranchM = pcbranch_q;
    o_exc_misalign   = exc_q | misalign_m;
  end

`ifdef ARC_BRANCH_STATS_EN
  logic [CNT_W-1:0] cnt_branch_q, cnt_taken_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_branch_q <= '0;
      cnt_taken_q  <= '0;
    end else if (!i_con_stall) begin
      if (valid_q && (branch_q || bne_q) && (cnt_branch_q != '1)) begin
        cnt_branch_q <= cnt_branch_q + 1'b1;
      end
      if (o_con_PCSrc && (cnt_taken_q != '1)) begin
        cnt_taken_q <= cnt_taken_q + 1'b1;
      end
    end
  end

  assign o_cnt_branch = cnt_branch_q;
  assign o_cnt_taken  = cnt_taken_q;
`else
  assign o_cnt_branch = '0;
  assign o_cnt_taken  = '0;
`endif

endmodule

// File: tb/tb_mem_branch_resolve.sv
// Directed bench for mem_branch_resolve; counters are checked narrow (3 bits) to reach saturation.
module tb_mem_branch_resolve;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned CNT_W = 3;
`ifdef ARC_BRANCH_STATS_EN
  localparam bit Stats = 1'b1;
`else
  localparam bit Stats = 1'b0;
`endif

  logic             clk, rst, stall, valid_e, branch_e, bne_e, zero_e, excack;
  logic [WIDTH-1:0] target_e, pcbranch_m;
  logic             pcsrc, flush_d, flush_e, exc;
  logic [CNT_W-1:0] cnt_branch, cnt_taken;

  int checks = 0;
  int errors = 0;

  mem_branch_resolve #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_con_stall      (stall),
    .i_con_validE     (valid_e),
    .i_con_branchE    (branch_e),
    .i_con_bneE       (bne_e),
    .i_flag_zeroE     (zero_e),
    .i_addr_pcbranchE (target_e),
    .i_con_excack     (excack),
    .o_addr_pcbranchM (pcbranch_m),
    .o_con_PCSrc      (pcsrc),
    .o_con_flushD     (flush_d),
    .o_con_flushE     (flush_e),
    .o_exc_misalign   (exc),
    .o_cnt_branch     (cnt_branch),
    .o_cnt_taken      (cnt_taken)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ex(input logic v, input logic beq, input logic bne, input logic z,
                          input logic [WIDTH-1:0] t);
    valid_e  = v;
    branch_e = beq;
    bne_e    = bne;
    zero_e   = z;
    target_e = t;
  endtask

  task automatic check_redirect(input string tag, input logic exp_sel);
    check_eq({tag, "_pcsrc"}, pcsrc, exp_sel);
    check_eq({tag, "_flushD"}, flush_d, exp_sel);
    check_eq({tag, "_flushE"}, flush_e, exp_sel);
  endtask

  task automatic check_counts(input string tag, input int br, input int tk);
    check_eq({tag, "_cnt_branch"}, cnt_branch, Stats ? br : 0);
    check_eq({tag, "_cnt_taken"}, cnt_taken, Stats ? tk : 0);
  endtask

  initial begin
    rst    = 1'b1;
    stall  = 1'b0;
    excack = 1'b0;
    drive_ex(1'b0, 1'b0, 1'b0, 1'b0, '0);
    #3;
    check_redirect("reset", 1'b0);
    check_eq("reset_addr", pcbranch_m, 0);
    check_eq("reset_exc", exc, 1'b0);
    check_counts("reset", 0, 0);
    @(negedge clk);
    rst = 1'b0;

    // Taken beq to 0x40, then self-squash.
    drive_ex(1'b1, 1'b1, 1'b0, 1'b1, 32'h40);
    tick();
    check_redirect("beq_taken", 1'b1);
    check_eq("beq_taken_addr", pcbranch_m, 32'h40);
    drive_ex(1'b0, 1'b0, 1'b0, 1'b0, '0);
    tick();
    check_redirect("beq_after", 1'b0);
    check_counts("beq", 1, 1);

    // Not-taken bne.
    drive_ex(1'b1, 1'b0, 1'b1, 1'b1, 32'h80);
    tick();
    check_redirect("bne_nt", 1'b0);
    drive_ex(1'b0, 1'b0, 1'b0, 1'b0, '0);
    tick();
    check_counts("bne_nt", 2, 1);

    // Stall for 3 cycles during a redirect; EX changes must be ignored.
    drive_ex(1'b1, 1'b1, 1'b0, 1'b1, 32'h100);
    tick();
    check_redirect("stall_pre", 1'b1);
    stall = 1'b1;
    drive_ex(1'b1, 1'b1, 1'b0, 1'b1, 32'h200);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("stall_pcsrc", pcsrc, 1'b1);
      check_eq("stall_addr", pcbranch_m, 32'h100);
    end
    check_counts("stall_hold", 2, 1);
    stall = 1'b0;
    tick();
    check_redirect("stall_release", 1'b0);
    check_counts("stall", 3, 2);
    drive_ex(1'b0, 1'b0, 1'b0, 1'b0, '0);
    tick();
    check_redirect("stall_squashed", 1'b0);

    // Back-to-back taken branches: the second is squashed.
    drive_ex(1'b1, 1'b1, 1'b0, 1'b1, 32'h300);
    tick();
    check_redirect("b2b_first", 1'b1);
    drive_ex(1'b1, 1'b1, 1'b0, 1'b1, 32'h400);
    tick();
    check_redirect("b2b_second", 1'b0);
    check_eq("b2b_addr", pcbranch_m, 32'h300);
    drive_ex(1'b0, 1'b0, 1'b0, 1'b0, '0);
    tick();
    check_redirect("b2b_after", 1'b0);
    check_counts("b2b", 4, 3);

    // Misaligned taken target: no redirect, sticky flag until ack.
    drive_ex(1'b1, 1'b1, 1'b0, 1'b1, 32'h42);
    tick();
    check_redirect("mis", 1'b0);
    check_eq("mis_exc", exc, 1'b1);
    check_eq("mis_addr", pcbranch_m, 32'h42);
    drive_ex(1'b0, 1'b0, 1'b0, 1'b0, '0);
    tick();
    check_eq("mis_sticky", exc, 1'b1);
    tick();
    check_eq("mis_sticky2", exc, 1'b1);
    excack = 1'b1;
    tick();
    excack = 1'b0;
    check_eq("mis_ack", exc, 1'b0);

    // Set and ack on the same edge: set wins.
    drive_ex(1'b1, 1'b1, 1'b0, 1'b1, 32'h43);
    tick();
    check_eq("mis2_exc", exc, 1'b1);
    excack = 1'b1;
    drive_ex(1'b0, 1'b0, 1'b0, 1'b0, '0);
    tick();
    check_eq("mis2_set_wins", exc, 1'b1);
    tick();
    excack = 1'b0;
    check_eq("mis2_ack", exc, 1'b0);
    check_counts("mis", 6, 3);

    // Branch counter saturates at all-ones (7 for 3 bits).
    for (int i = 0; i < 2; i++) begin
      drive_ex(1'b1, 1'b1, 1'b0, 1'b0, 32'h10);
      tick();
      check_eq("sat_pcsrc", pcsrc, 1'b0);
      drive_ex(1'b0, 1'b0, 1'b0, 1'b0, '0);
      tick();
    end
    check_counts("sat", 7, 3);

    // Async reset while in HOLD.
    drive_ex(1'b1, 1'b1, 1'b0, 1'b1, 32'h500);
    tick();
    check_redirect("hold_pre", 1'b1);
    stall = 1'b1;
    drive_ex(1'b0, 1'b0, 1'b0, 1'b0, '0);
    tick();
    check_eq("hold_pcsrc", pcsrc, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check_redirect("async_rst", 1'b0);
    check_eq("async_rst_addr", pcbranch_m, 0);
    check_eq("async_rst_exc", exc, 1'b0);
    check_counts("async_rst", 0, 0);
    stall = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    tick();
    check_redirect("post_rst", 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
